// File: rtl/fc_binary_layer.sv
// Binary fully-connected layer: XNOR-popcount of a registered activation vector against
// streamed weight words, producing saturated Q8.8 class scores plus bias.
module fc_binary_layer #(
    parameter int unsigned IN_BITS = 64,
    parameter int unsigned WORD    = 16,
    parameter int unsigned OC      = 10,
    localparam int unsigned WPO    = IN_BITS / WORD,
    localparam int unsigned AW     = $clog2(OC * WPO)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_in_ready,
    input  logic [IN_BITS-1:0]  in_bits,
    input  logic signed [15:0]  bias [0:OC-1],
    output logic                w_en,
    output logic [AW-1:0]       w_addr,
    input  logic [WORD-1:0]     w_data,
    output logic signed [15:0]  out [0:OC-1],
    output logic                data_out_ready,
    output logic                busy
);

    localparam int unsigned KW = $clog2(WPO + 1);
    localparam int unsigned OW = (OC > 1) ? $clog2(OC) : 1;
    localparam int unsigned PW = 8;

    typedef enum logic [1:0] {StIdle, StLoad, StAcc, StDone} state_e;

    state_e                state_q, state_d;
    logic [OW-1:0]         o_q, o_d;
    logic [KW-1:0]         k_q, k_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [IN_BITS-1:0]    x_q;
    logic signed [15:0]    bias_q [0:OC-1];
    logic signed [15:0]    out_q  [0:OC-1];

    logic                  capture, write_out, clear_out;
    logic [WORD-1:0]       x_word;
    logic [PW-1:0]         pc_sum;
    logic signed [15:0]    bias_sel;
    logic signed [17:0]    s_val, v_val;
    logic signed [15:0]    sat;

    function automatic logic [PW-1:0] popcount(input logic [WORD-1:0] v);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WORD; i++) begin
            cnt = cnt + PW'(v[i]);
        end
        return cnt;
    endfunction

    // Weight data arrives one cycle after its address, so ACC cycle k scores word k-1.
    always_comb begin : datapath
        x_word = '0;
        for (int i = 0; i < WPO; i++) begin
            if (k_q == KW'(i + 1)) x_word = x_q[i*WORD +: WORD];
        end
        pc_sum = acc_q + popcount(~(x_word ^ w_data));
        bias_sel = '0;
        for (int i = 0; i < OC; i++) begin
            if (o_q == OW'(i)) bias_sel = bias_q[i];
        end
        s_val = $signed({{(18 - PW - 1){1'b0}}, pc_sum, 1'b0}) - $signed(18'(IN_BITS));
        v_val = (s_val <<< 8) + $signed({{2{bias_sel[15]}}, bias_sel});
        if (v_val > 18'sd32767) begin
            sat = 16'sh7FFF;
        end else if (v_val < -18'sd32768) begin
            sat = 16'sh8000;
        end else begin
            sat = v_val[15:0];
        end
    end

    always_comb begin : fsm
        state_d   = state_q;
        o_d       = o_q;
        k_d       = k_q;
        acc_d     = acc_q;
        capture   = 1'b0;
        write_out = 1'b0;
        clear_out = 1'b0;
        w_en      = 1'b0;
        w_addr    = '0;
        unique case (state_q)
            StIdle: begin
                if (data_in_ready) begin
                    capture = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                o_d     = '0;
                k_d     = '0;
                acc_d   = '0;
                state_d = StAcc;
            end
            StAcc: begin
                if (k_q < KW'(WPO)) begin
                    w_en   = 1'b1;
                    w_addr = AW'(o_q) * AW'(WPO) + AW'(k_q);
                end
                if (k_q != '0) acc_d = pc_sum;
                if (k_q == KW'(WPO)) begin
                    write_out = 1'b1;
                    acc_d     = '0;
                    k_d       = '0;
                    if (o_q == OW'(OC - 1)) begin
                        state_d = StDone;
                    end else begin
                        o_d = o_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
        // Dropping the input handshake aborts any job and is also how a new one is armed.
        if (!data_in_ready) begin
            state_d   = StIdle;
            o_d       = '0;
            k_d       = '0;
            acc_d     = '0;
            clear_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            o_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            for (int i = 0; i < OC; i++) begin
                bias_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            if (capture) begin
                x_q    <= in_bits;
                bias_q <= bias;
            end
            for (int i = 0; i < OC; i++) begin
                if (clear_out) begin
                    out_q[i] <= '0;
                end else if (write_out && (o_q == OW'(i))) begin
                    out_q[i] <= sat;
                end
            end
        end
    end

    assign out            = out_q;
    assign data_out_ready = (state_q == StDone);
    assign busy           = (state_q == StLoad) || (state_q == StAcc);

endmodule

// File: tb/tb_fc_binary_layer.sv
// Bench for fc_binary_layer: table of jobs with a weight-memory model, a scoreboard of
// expected scores, cycle-exact fetch/latency checks, and abort/reset restart sequences.
module tb_fc_binary_layer;

    localparam int OC      = 10;
    localparam int IN_BITS = 64;
    localparam int WORD    = 16;
    localparam int WPO     = IN_BITS / WORD;
    localparam int NW      = OC * WPO;
    localparam int LAT     = OC * (WPO + 1) + 2;

    typedef logic [OC-1:0][15:0] outv_t;
    typedef struct {
        logic [IN_BITS-1:0] x;
        logic [15:0]        w0;
        logic [15:0]        wn;
        outv_t              b;
        outv_t              e;
        int                 cls;
        bit                 rnd;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 data_in_ready;
    logic [IN_BITS-1:0]   in_bits;
    logic signed [15:0]   bias [0:OC-1];
    logic                 w_en;
    logic [5:0]           w_addr;
    logic [WORD-1:0]      w_data;
    logic signed [15:0]   out_w [0:OC-1];
    logic                 data_out_ready;
    logic                 busy;

    logic [15:0] wmem [0:NW-1];
    outv_t       sb_q [$];
    outv_t       cur_exp;
    int          cur_cls;
    int          n_chk  = 0;
    int          n_pass = 0;
    vec_t        tab [$];

    always #5 clk = ~clk;

    fc_binary_layer #(
        .IN_BITS (IN_BITS),
        .WORD    (WORD),
        .OC      (OC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_ready  (data_in_ready),
        .in_bits        (in_bits),
        .bias           (bias),
        .w_en           (w_en),
        .w_addr         (w_addr),
        .w_data         (w_data),
        .out            (out_w),
        .data_out_ready (data_out_ready),
        .busy           (busy)
    );

    // Weight memory: answers one cycle after a strobe, junk otherwise.
    initial begin
        logic       en;
        logic [5:0] a;
        w_data = '0;
        forever begin
            @(negedge clk);
            en = w_en;
            a  = w_addr;
            @(posedge clk);
            #1;
            if (en && (a < 6'(NW))) w_data = wmem[a];
            else                    w_data = 16'($urandom);
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic outv_t pack_out();
        outv_t r;
        for (int i = 0; i < OC; i++) r[i] = out_w[i];
        return r;
    endfunction

    // Reference: bitwise agreement count per class, then Q8.8 scale, bias and clamp.
    function automatic outv_t model(input logic [IN_BITS-1:0] x, input outv_t b);
        outv_t r;
        for (int o = 0; o < OC; o++) begin
            int          pc;
            int          v;
            logic [15:0] w;
            pc = 0;
            for (int j = 0; j < IN_BITS; j++) begin
                w = wmem[o*WPO + j/WORD];
                if (x[j] == w[j%WORD]) pc++;
            end
            v = (2*pc - IN_BITS) * 256 + int'($signed(b[o]));
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            r[o] = 16'(v);
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [IN_BITS-1:0] x, input logic [15:0] w0,
                                input logic [15:0] wn, input logic [15:0] efill, input int pi,
                                input logic [15:0] bp, input logic [15:0] ep, input int cls,
                                input bit rnd);
        vec_t v;
        v.x = x;  v.w0 = w0;  v.wn = wn;
        v.b = '0;
        v.b[pi] = bp;
        v.e = {OC{efill}};
        v.e[pi] = ep;
        v.cls = cls;  v.rnd = rnd;
        return v;
    endfunction

    task automatic launch(input vec_t v);
        logic [IN_BITS-1:0] x;
        outv_t              b, e;
        if (v.rnd) begin
            x = {$urandom, $urandom};
            for (int a = 0; a < NW; a++) wmem[a] = 16'($urandom);
            for (int i = 0; i < OC; i++) b[i] = 16'($urandom);
            e = model(x, b);
        end else begin
            for (int a = 0; a < NW; a++) wmem[a] = (a < WPO) ? v.w0 : v.wn;
            x = v.x;
            b = v.b;
            e = v.e;
        end
        in_bits = x;
        for (int i = 0; i < OC; i++) bias[i] = b[i];
        data_in_ready = 1'b1;
        sb_q.push_back(e);
        cur_cls = v.cls;
    endtask

    // Called in cycle 0; walks cycles 1..LAT checking the fetch schedule and handshakes.
    task automatic run_to_done(input string tag);
        outv_t got;
        int    best;
        for (int n = 1; n <= LAT; n++) begin
            logic       e_en, e_busy, e_dor;
            logic [5:0] e_addr;
            int         k;
            @(posedge clk);
            #1;
            k      = (n - 2) % (WPO + 1);
            e_en   = (n >= 2) && (n < LAT) && (k < WPO);
            e_addr = 6'(((n - 2) / (WPO + 1)) * WPO + k);
            e_busy = (n < LAT);
            e_dor  = (n == LAT);
            check($sformatf("%s w_en c%0d", tag, n), w_en, e_en);
            if (e_en) check($sformatf("%s w_addr c%0d", tag, n), w_addr, e_addr);
            check($sformatf("%s busy c%0d", tag, n), busy, e_busy);
            check($sformatf("%s data_out_ready c%0d", tag, n), data_out_ready, e_dor);
        end
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
            cur_exp = '0;
        end else begin
            cur_exp = sb_q.pop_front();
        end
        got = pack_out();
        for (int i = 0; i < OC; i++) check($sformatf("%s out[%0d]", tag, i), got[i], cur_exp[i]);
        if (cur_cls >= 0) begin
            best = 0;
            for (int i = 1; i < OC; i++) if ($signed(got[i]) > $signed(got[best])) best = i;
            check({tag, " argmax"}, best, cur_cls);
        end
    endtask

    // Holds DONE with wiggling inputs, then drops data_in_ready and expects a clean IDLE.
    task automatic hold_and_release(input string tag);
        for (int c = 0; c < 3; c++) begin
            in_bits = {$urandom, $urandom};
            for (int i = 0; i < OC; i++) bias[i] = 16'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("%s hold dor %0d", tag, c), data_out_ready, 1'b1);
            check($sformatf("%s hold w_en %0d", tag, c), w_en, 1'b0);
            check($sformatf("%s hold out %0d", tag, c), pack_out(), cur_exp);
        end
        data_in_ready = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " release dor"}, data_out_ready, 1'b0);
        check({tag, " release out"}, pack_out(), '0);
        check({tag, " release busy"}, busy, 1'b0);
    endtask

    // mode 0: data_in_ready low in cycles 20-21; mode 1: rst high in cycles 20-21.
    task automatic abort_restart(input int mode, input vec_t v);
        string tag;
        outv_t got;
        tag = (mode == 0) ? "abort" : "rst_abort";
        launch(v);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
        end
        got = pack_out();
        check({tag, " partial out[0]"}, got[0], v.e[0]);
        if (mode == 0) data_in_ready = 1'b0;
        else           rst = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        check({tag, " c21 dor"}, data_out_ready, 1'b0);
        check({tag, " c21 out"}, pack_out(), '0);
        check({tag, " c21 busy"}, busy, 1'b0);
        check({tag, " c21 w_en"}, w_en, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        launch(v);
        run_to_done(tag);
        hold_and_release(tag);
    endtask

    initial begin
        rst           = 1'b1;
        data_in_ready = 1'b0;
        in_bits       = '0;
        w_en_unused_guard();
        for (int i = 0; i < OC; i++) bias[i] = '0;
        for (int a = 0; a < NW; a++) wmem[a] = '0;

        tab.push_back(mk({4{16'hFFFF}}, 16'hFFFF, 16'hFFFF, 16'h4000, 0, 16'h0000, 16'h4000,
                         -1, 1'b0));
        tab.push_back(mk({4{16'hFFFF}}, 16'h0000, 16'h0000, 16'hC000, 3, 16'h0080, 16'hC080,
                         3, 1'b0));
        tab.push_back(mk({4{16'hAAAA}}, 16'hAAAA, 16'h5555, 16'hC000, 0, 16'h0000, 16'h4000,
                         0, 1'b0));
        tab.push_back(mk({4{16'hFFFF}}, 16'hFFFF, 16'hFFFF, 16'h4000, 0, 16'h7FFF, 16'h7FFF,
                         0, 1'b0));
        tab.push_back(mk({4{16'hFFFF}}, 16'h0000, 16'h0000, 16'hC000, 1, 16'h8000, 16'h8000,
                         -1, 1'b0));
        tab.push_back(mk('0, '0, '0, '0, 0, '0, '0, -1, 1'b1));
        tab.push_back(mk('0, '0, '0, '0, 0, '0, '0, -1, 1'b1));

        repeat (3) @(posedge clk);
        #1;
        check("reset dor", data_out_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset w_en", w_en, 1'b0);
        check("reset w_addr", w_addr, 6'd0);
        check("reset out", pack_out(), '0);

        data_in_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst priority busy", busy, 1'b0);
        check("rst priority dor", data_out_ready, 1'b0);
        rst           = 1'b0;
        data_in_ready = 1'b0;
        @(posedge clk);
        #1;
        check("post reset idle busy", busy, 1'b0);

        for (int t = 0; t < tab.size(); t++) begin
            launch(tab[t]);
            run_to_done($sformatf("vec%0d", t));
            hold_and_release($sformatf("vec%0d", t));
        end

        abort_restart(0, tab[0]);
        abort_restart(1, tab[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic w_en_unused_guard();
        cur_cls = -1;
        cur_exp = '0;
    endtask

endmodule

// File: doc/fc_binary_layer.md
FC_BINARY_LAYER -- requirements
Module: fc_binary_layer

Interface
REQ-001 The block SHALL have the parameter IN_BITS, default 64, giving the binary input feature length; IN_BITS SHALL be a multiple of WORD and at most 127.
REQ-002 The block SHALL have the parameter WORD, default 16, giving the weight bits fetched per cycle.
REQ-003 The block SHALL have the parameter OC, default 10, giving the number of output classes.
REQ-004 Derived values SHALL be WPO = IN_BITS/WORD (words per output) and AW = $clog2(OC*WPO).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port data_in_ready, input, 1 bit: level-valid for in_bits and bias from the upstream stage; low aborts the job.
REQ-008 The block SHALL have port in_bits, input, IN_BITS bits: binary activations, where bit=1 means +1 and bit=0 means -1.
REQ-009 The block SHALL have port bias, input, signed [15:0] [0:OC-1]: per-class bias in Q8.8.
REQ-010 The block SHALL have port w_en, output, 1 bit: weight memory read strobe.
REQ-011 The block SHALL have port w_addr, output, AW bits: weight word address.
REQ-012 The block SHALL have port w_data, input, WORD bits: weight word returned exactly 1 cycle after the w_en/w_addr cycle.
REQ-013 The block SHALL have port out, output, signed [15:0] [0:OC-1]: class scores in Q8.8, feeding the comparator stage.
REQ-014 The block SHALL have port data_out_ready, output, 1 bit: out is valid and stable.
REQ-015 The block SHALL have port busy, output, 1 bit: high while the block is in LOAD or ACC.

Function
REQ-016 The state machine SHALL have the states IDLE, LOAD, ACC and DONE.
REQ-017 In IDLE, when data_in_ready=1 is sampled, the block SHALL register in_bits and bias and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 LOAD SHALL last 1 cycle, clearing the class index o and the word index k to 0 and the popcount accumulator to 0, and SHALL then go to ACC.
REQ-019 ACC SHALL take WPO+1 cycles per class; in ACC cycle k < WPO the block SHALL assert w_en=1 with w_addr = o*WPO + k, and in cycle k = WPO it SHALL drive w_en=0.
REQ-020 In ACC cycle k >= 1, the block SHALL add popcount(~(x_word XNOR-mismatch)) to the accumulator, i.e. popcount(x[(k-1)*WORD +: WORD] XNOR w_data), where w_data bit j pairs with x bit (k-1)*WORD+j.
REQ-021 In ACC cycle k = WPO, the block SHALL form s = 2*pc_total - IN_BITS (signed, range ±IN_BITS), compute v = s*256 + bias[o], and register out[o] = v saturated to [-32768, 32767].
REQ-022 In the same cycle as REQ-021, the block SHALL clear the accumulator and k; it SHALL then increment o, or, if o = OC-1, go to DONE.
REQ-023 All intermediate arithmetic SHALL use at least 18-bit signed width, so that saturation is exact.
REQ-024 In DONE the block SHALL hold data_out_ready=1 and out stable for as long as data_in_ready=1, and SHALL ignore changes on in_bits, bias and w_data.
REQ-025 In any state, data_in_ready=0 SHALL cause the next state to be IDLE with data_out_ready=0, all out entries=0, w_en=0 and busy=0; this is the abort behaviour and also the way to start a new job.
REQ-026 Latency: if data_in_ready is first sampled high in IDLE at cycle 0, data_out_ready SHALL rise at cycle OC*(WPO+1)+2, which is cycle 52 for the default parameters.
REQ-027 w_addr SHALL never exceed OC*WPO-1, and w_en SHALL be low outside ACC.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL enter IDLE and drive out[*]=0, data_out_ready=0, busy=0, w_en=0 and w_addr=0, with the accumulator, o and k all at 0.
REQ-029 rst SHALL have priority over data_in_ready, and a reset mid-job SHALL discard all partial results.
REQ-030 After rst is released, the block SHALL start a job only on a data_in_ready=1 sample taken in IDLE.

Verification
REQ-031 With defaults, in_bits all-ones, every weight word 0xFFFF and bias 0, the bench SHALL check that every out is 0x4000 (+64.0) and that data_out_ready rises at cycle 52.
REQ-032 With in_bits all-ones, every weight word 0x0000 and bias[3]=0x0080, the bench SHALL check that out[3]=0xC080 (-63.5) and all other out entries are 0xC000.
REQ-033 With alternating in_bits 0xAAAA... and weights 0xAAAA for class 0 and 0x5555 for all other classes, the bench SHALL check that out[0]=0x4000, all other out entries are 0xC000, and the comparator stage downstream reports class 0.
REQ-034 With all-match weights and bias[0]=0x7FFF, the bench SHALL check that out[0]=0x7FFF (saturated); with all-mismatch weights and bias[1]=0x8000, it SHALL check that out[1]=0x8000 (saturated).
REQ-035 Dropping data_in_ready at cycle 20 and raising it again at cycle 22 SHALL produce data_out_ready=0 and out all zero at cycle 21, followed by a full restart with data_out_ready rising 52 cycles after cycle 22; the same scenario with rst applied at cycle 20 instead SHALL give the same response.
REQ-036 The bench SHALL check the w_addr sequence 0,1,2,3 (gap) 4,5,6,7 (gap) ... 39, with w_en low in each gap cycle and throughout DONE.
